store_queue: RTL and testbench
==============================

# store_queue

Write-side companion of the memory stage: accepts store operations from the execute stage, formats byte-lane write data and strobes for SB/SH/SW (and SWL/SWR when configured), buffers them in a small in-order queue, and issues them on the data-SRAM request channel (req/addr_ok/data_ok handshake). It sits between the execute stage and the data-SRAM arbiter. It reports when all stores have completed, so the memory stage can order later loads behind earlier stores.

## Interface
Parameters:
- DEPTH, 4, queue entries (power of two, ≥2)
- MAX_OUTSTANDING, 2, accepted-but-unacknowledged requests allowed (1..3)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- st_valid  in  1  store offered by execute stage
- st_ready  out  1  queue can accept this cycle
- st_op  in  3  000 SB, 001 SH, 010 SW, 011 SWL, 100 SWR; other codes are illegal
- st_addr  in  32  effective byte address
- st_rt_value  in  32  rt register value
- data_sram_req  out  1  request valid
- data_sram_wr  out  1  constant 1 while req is high
- data_sram_size  out  2  0 byte, 1 half, 2 word
- data_sram_addr  out  32  request address
- data_sram_wstrb  out  4  byte-lane enables
- data_sram_wdata  out  32  lane-aligned write data
- data_sram_addr_ok  in  1  request accepted
- data_sram_data_ok  in  1  write completed, in order
- sq_empty  out  1  queue empty and no request outstanding
- sq_count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Enqueue when st_valid && st_ready. st_ready = count < DEPTH, with no same-cycle pass-through when full.
- Formatting is done at enqueue and stores {addr, size, wstrb, wdata}. With a = st_addr[1:0] and rt = st_rt_value:
  - SB: size 0, addr = st_addr, wstrb = 1<<a, wdata = {4{rt[7:0]}}.
  - SH: size 1, addr = st_addr, wstrb = a[1] ? 1100 : 0011, wdata = {2{rt[15:0]}}. a[0] is ignored; alignment exceptions are filtered upstream.
  - SW: size 2, addr = st_addr, wstrb 1111, wdata = rt.
  - SWL: size 2, addr = {st_addr[31:2],00}.
    - a = 0: wstrb 0001, wdata rt>>24.
    - a = 1: wstrb 0011, wdata rt>>16.
    - a = 2: wstrb 0111, wdata rt>>8.
    - a = 3: wstrb 1111, wdata rt.
  - SWR: size 2, aligned addr.
    - a = 0: wstrb 1111, wdata rt.
    - a = 1: wstrb 1110, wdata rt<<8.
    - a = 2: wstrb 1100, wdata rt<<16.
    - a = 3: wstrb 1000, wdata rt<<24.
- Issue:
  - data_sram_req = !queue_empty && outstanding < MAX_OUTSTANDING.
  - Request fields always come from the head entry.
  - The head pops on req && addr_ok.
  - While req is high without addr_ok, all request fields hold stable.
- Outstanding counter:
  - +1 on req && addr_ok; −1 on data_ok.
  - Both in the same cycle leaves it unchanged.
  - data_ok while the counter is 0 is ignored (saturates at 0).
- Simultaneous enqueue and pop: count unchanged, pointers both advance; wrap at DEPTH.
- sq_empty = count == 0 && outstanding == 0.

## Timing
- Reset values:
  - st_ready 1, sq_empty 1, sq_count 0.
  - data_sram_req 0, data_sram_wr 0, data_sram_size 0, data_sram_addr 0, data_sram_wstrb 0, data_sram_wdata 0.
  - Pointers and outstanding counter 0.
- Latency: a store enqueued in cycle N can raise req in cycle N+1 at the earliest, because the queue is registered.
- Throughput: one issue per cycle while addr_ok stays high and the outstanding limit allows it.
- Reset mid-transaction: the queue is discarded. A later data_ok for a pre-reset request is ignored.
- All outputs are derived from registers only; there are no combinational paths from st_* to data_sram_*.

## Configuration
- STORE_QUEUE_UNALIGNED_EN
  - Defined: SWL/SWR are formatted as specified above.
  - Undefined: opcodes 011/100 are accepted but enqueued with wstrb 0000. They still issue and complete, as a no-write slot, and the SWL/SWR formatting logic is absent.

## Structure
- Shared package or mycpu.h holds:
  - st_op encodings (ST_OP_SB..ST_OP_SWR).
  - The SIZE_BYTE/HALF/WORD constants.
  - The queue entry width constant (32+2+4+32 = 70).
- One sub-module, store_formatter: combinational, {st_op, st_addr, st_rt_value} → {addr, size, wstrb, wdata}. It holds all lane logic and the _EN gating.
- The top level holds the circular queue, pointers, outstanding counter and handshake.

## Test plan
- SB at 0x1003 with rt=0x000000A5, addr_ok/data_ok immediate → one request: addr 0x1003, size 0, wstrb 1000, wdata 0xA5A5A5A5; sq_empty returns to 1.
- SH at 0x2002 with rt=0x1234BEEF, then SW at 0x2004 with rt=0xCAFEF00D, back-to-back → wstrb 1100 with wdata 0xBEEFBEEF, then wstrb 1111 with wdata 0xCAFEF00D, in order on consecutive cycles.
- SWL at 0x3001 and SWR at 0x3001, rt=0x11223344 (macro defined) → first: addr 0x3000, wstrb 0011, wdata 0x00001122; second: wstrb 1110, wdata 0x22334400. Macro undefined → both issue with wstrb 0000.
- addr_ok held low for 10 cycles while 5 stores are offered → st_ready drops after 4 enqueues, and req fields stay stable. Raising addr_ok drains all 5 in order.
- data_ok withheld, MAX_OUTSTANDING=2, 3 queued stores → exactly 2 accepted, req low with sq_count=1. One data_ok → third request issues the next cycle.
- Reset asserted with 2 queued and 1 outstanding, then a stray data_ok → all outputs at reset values, and the counter stays 0.

Source files
------------

// File: rtl/store_queue_pkg.sv
// store_queue_pkg: store opcodes, access sizes and queue entry layout shared by the store queue.
package store_queue_pkg;
  typedef enum logic [2:0] {
    ST_OP_SB  = 3'b000,
    ST_OP_SH  = 3'b001,
    ST_OP_SW  = 3'b010,
    ST_OP_SWL = 3'b011,
    ST_OP_SWR = 3'b100
  } st_op_e;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam int SQ_ENTRY_W = 32 + 2 + 4 + 32;
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } sq_entry_t;
endpackage

// File: rtl/store_queue_if.sv
// store_queue_if: execute-stage store channel, data-SRAM write request channel and queue status.
interface store_queue_if #(parameter int DEPTH = 4);
  logic                     st_valid;
  logic                     st_ready;
  logic [2:0]               st_op;
  logic [31:0]              st_addr;
  logic [31:0]              st_rt_value;
  logic                     data_sram_req;
  logic                     data_sram_wr;
  logic [1:0]               data_sram_size;
  logic [31:0]              data_sram_addr;
  logic [3:0]               data_sram_wstrb;
  logic [31:0]              data_sram_wdata;
  logic                     data_sram_addr_ok;
  logic                     data_sram_data_ok;
  logic                     sq_empty;
  logic [$clog2(DEPTH):0]   sq_count;
  modport master (
    output st_valid, st_op, st_addr, st_rt_value, data_sram_addr_ok, data_sram_data_ok,
    input  st_ready, data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata, sq_empty, sq_count
  );
  modport slave (
    input  st_valid, st_op, st_addr, st_rt_value, data_sram_addr_ok, data_sram_data_ok,
    output st_ready, data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata, sq_empty, sq_count
  );
endinterface

// File: rtl/store_queue_formatter.sv
// store_formatter: lane-aligns store data and strobes; SWL/SWR lanes exist only with STORE_QUEUE_UNALIGNED_EN.
module store_formatter
  import store_queue_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] rt_i,
  output sq_entry_t   entry_o
);
  logic [1:0] a;
  assign a = addr_i[1:0];
  always_comb begin
    entry_o = '0;
    entry_o.addr = addr_i;
    entry_o.size = SIZE_WORD;
    case (op_i)
      ST_OP_SB: begin
        entry_o.size  = SIZE_BYTE;
        entry_o.wstrb = 4'b0001 << a;
        entry_o.wdata = {4{rt_i[7:0]}};
      end
      ST_OP_SH: begin
        entry_o.size  = SIZE_HALF;
        entry_o.wstrb = a[1] ? 4'b1100 : 4'b0011;
        entry_o.wdata = {2{rt_i[15:0]}};
      end
      ST_OP_SW: begin
        entry_o.wstrb = 4'b1111;
        entry_o.wdata = rt_i;
      end
      ST_OP_SWL: begin
        entry_o.addr = {addr_i[31:2], 2'b00};
`ifdef STORE_QUEUE_UNALIGNED_EN
        entry_o.wstrb = 4'b1111 >> ~a;
        entry_o.wdata = rt_i >> {~a, 3'b000};
`else
        entry_o.wstrb = 4'b0000;
`endif
      end
      ST_OP_SWR: begin
        entry_o.addr = {addr_i[31:2], 2'b00};
`ifdef STORE_QUEUE_UNALIGNED_EN
        entry_o.wstrb = 4'b1111 << a;
        entry_o.wdata = rt_i << {a, 3'b000};
`else
        entry_o.wstrb = 4'b0000;
`endif
      end
      default: entry_o.wstrb = 4'b0000;
    endcase
  end
endmodule

// File: rtl/store_queue.sv
// store_queue: in-order store buffer issuing formatted writes on the data-SRAM channel.
// SWL/SWR formatting is enabled by defining STORE_QUEUE_UNALIGNED_EN.
module store_queue
  import store_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic clk,
  input logic reset,
  store_queue_if.slave sq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  sq_entry_t mem_q [DEPTH];
  sq_entry_t fmt, head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0] out_q, out_d;
  logic enq, pop, req, dok;
  store_formatter u_fmt (
    .op_i   (sq.st_op),
    .addr_i (sq.st_addr),
    .rt_i   (sq.st_rt_value),
    .entry_o(fmt)
  );
  assign head = mem_q[rd_ptr_q];
  assign sq.st_ready = count_q < CW'(DEPTH);
  assign req = count_q != '0 && out_q < 2'(MAX_OUTSTANDING);
  assign enq = sq.st_valid && sq.st_ready;
  assign pop = req && sq.data_sram_addr_ok;
  // a data_ok with nothing outstanding belongs to a discarded request
  assign dok = sq.data_sram_data_ok && out_q != '0;
  assign sq.data_sram_req = req;
  assign sq.data_sram_wr = req;
  assign sq.data_sram_size = req ? head.size : '0;
  assign sq.data_sram_addr = req ? head.addr : '0;
  assign sq.data_sram_wstrb = req ? head.wstrb : '0;
  assign sq.data_sram_wdata = req ? head.wdata : '0;
  assign sq.sq_empty = count_q == '0 && out_q == '0;
  assign sq.sq_count = count_q;
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(enq);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + CW'(enq) - CW'(pop);
    out_d = out_q + 2'(pop) - 2'(dok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      out_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      out_q <= out_d;
    end
  end
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= fmt;
  end
endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: directed checks of formatting, ordering, back-pressure, outstanding limit and reset.
module tb_store_queue;
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          cyc;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int pend = 0;
  bit auto_dok = 1'b0;
  rec_t log_q[$];

  store_queue_if #(.DEPTH(4)) ifc ();
  store_queue #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (.clk(clk), .reset(reset), .sq(ifc));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifc.data_sram_req && ifc.data_sram_addr_ok) begin
      log_q.push_back('{ifc.data_sram_addr, ifc.data_sram_size, ifc.data_sram_wstrb, ifc.data_sram_wdata, cyc});
      pend++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ifc.data_sram_data_ok && pend > 0) pend--;
    ifc.data_sram_data_ok = auto_dok && pend > 0;
  endtask

  task automatic enq(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rt);
    ifc.st_valid = 1'b1;
    ifc.st_op = op;
    ifc.st_addr = addr;
    ifc.st_rt_value = rt;
    step();
    ifc.st_valid = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    for (int i = 0; i < 50 && !ifc.sq_empty; i++) step();
    chk(tag, ifc.sq_empty, 1);
  endtask

  initial begin
    int k;
    bit acc;
    ifc.st_valid = 1'b0;
    ifc.st_op = '0;
    ifc.st_addr = '0;
    ifc.st_rt_value = '0;
    ifc.data_sram_addr_ok = 1'b0;
    ifc.data_sram_data_ok = 1'b0;
    step();
    step();
    chk("rst_ready", ifc.st_ready, 1);
    chk("rst_empty", ifc.sq_empty, 1);
    chk("rst_count", ifc.sq_count, 0);
    chk("rst_req", ifc.data_sram_req, 0);
    chk("rst_wr", ifc.data_sram_wr, 0);
    chk("rst_addr", ifc.data_sram_addr, 0);
    reset = 1'b0;

    // SB with immediate handshakes
    auto_dok = 1'b1;
    ifc.data_sram_addr_ok = 1'b1;
    log_q.delete();
    enq(3'b000, 32'h1003, 32'h0000_00A5);
    chk("sb_req", ifc.data_sram_req, 1);
    chk("sb_wr", ifc.data_sram_wr, 1);
    chk("sb_addr", ifc.data_sram_addr, 32'h1003);
    chk("sb_size", ifc.data_sram_size, 0);
    chk("sb_wstrb", ifc.data_sram_wstrb, 4'b1000);
    chk("sb_wdata", ifc.data_sram_wdata, 32'hA5A5_A5A5);
    wait_empty("sb_empty");
    chk("sb_nreq", log_q.size(), 1);

    // SH then SW back to back
    log_q.delete();
    enq(3'b001, 32'h2002, 32'h1234_BEEF);
    enq(3'b010, 32'h2004, 32'hCAFE_F00D);
    wait_empty("shsw_empty");
    chk("shsw_n", log_q.size(), 2);
    chk("sh_addr", log_q[0].addr, 32'h2002);
    chk("sh_size", log_q[0].size, 1);
    chk("sh_wstrb", log_q[0].wstrb, 4'b1100);
    chk("sh_wdata", log_q[0].wdata, 32'hBEEF_BEEF);
    chk("sw_addr", log_q[1].addr, 32'h2004);
    chk("sw_wstrb", log_q[1].wstrb, 4'b1111);
    chk("sw_wdata", log_q[1].wdata, 32'hCAFE_F00D);
    chk("shsw_gap", log_q[1].cyc - log_q[0].cyc, 1);

    // SWL / SWR
    log_q.delete();
    enq(3'b011, 32'h3001, 32'h1122_3344);
    enq(3'b100, 32'h3001, 32'h1122_3344);
    wait_empty("swlr_empty");
    chk("swlr_n", log_q.size(), 2);
    chk("swl_addr", log_q[0].addr, 32'h3000);
    chk("swl_size", log_q[0].size, 2);
    chk("swr_addr", log_q[1].addr, 32'h3000);
`ifdef STORE_QUEUE_UNALIGNED_EN
    chk("swl_wstrb", log_q[0].wstrb, 4'b0011);
    chk("swl_wdata", log_q[0].wdata, 32'h0000_1122);
    chk("swr_wstrb", log_q[1].wstrb, 4'b1110);
    chk("swr_wdata", log_q[1].wdata, 32'h2233_4400);
`else
    chk("swl_wstrb", log_q[0].wstrb, 4'b0000);
    chk("swr_wstrb", log_q[1].wstrb, 4'b0000);
`endif

    // back-pressure: addr_ok low while 5 stores are offered
    log_q.delete();
    ifc.data_sram_addr_ok = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      ifc.st_valid = k < 5;
      ifc.st_op = 3'b010;
      ifc.st_addr = 32'h4000 + 32'(4 * k);
      ifc.st_rt_value = 32'(k + 1);
      acc = ifc.st_valid && ifc.st_ready;
      step();
      if (acc) k++;
      chk("stall_addr", ifc.data_sram_addr, 32'h4000);
    end
    chk("stall_wdata", ifc.data_sram_wdata, 1);
    chk("stall_accepted", k, 4);
    chk("stall_ready", ifc.st_ready, 0);
    chk("stall_count", ifc.sq_count, 4);
    ifc.data_sram_addr_ok = 1'b1;
    for (int i = 0; i < 40 && !(k == 5 && ifc.sq_empty); i++) begin
      ifc.st_valid = k < 5;
      ifc.st_addr = 32'h4000 + 32'(4 * k);
      ifc.st_rt_value = 32'(k + 1);
      acc = ifc.st_valid && ifc.st_ready;
      step();
      if (acc) k++;
    end
    ifc.st_valid = 1'b0;
    chk("drain_empty", ifc.sq_empty, 1);
    chk("drain_n", log_q.size(), 5);
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      chk("drain_addr", log_q[i].addr, 32'h4000 + 32'(4 * i));
      chk("drain_wdata", log_q[i].wdata, 32'(i + 1));
    end

    // outstanding limit with data_ok withheld
    log_q.delete();
    auto_dok = 1'b0;
    enq(3'b010, 32'h5000, 32'h1);
    enq(3'b010, 32'h5004, 32'h2);
    enq(3'b010, 32'h5008, 32'h3);
    step();
    step();
    step();
    chk("lim_n", log_q.size(), 2);
    chk("lim_req", ifc.data_sram_req, 0);
    chk("lim_count", ifc.sq_count, 1);
    ifc.data_sram_data_ok = 1'b1;
    step();
    chk("lim_req2", ifc.data_sram_req, 1);
    chk("lim_addr2", ifc.data_sram_addr, 32'h5008);
    auto_dok = 1'b1;
    wait_empty("lim_empty");
    chk("lim_n3", log_q.size(), 3);

    // reset with 2 queued and 1 outstanding, then a stray data_ok
    auto_dok = 1'b0;
    ifc.data_sram_addr_ok = 1'b0;
    enq(3'b010, 32'h6000, 32'h1);
    enq(3'b010, 32'h6004, 32'h2);
    enq(3'b010, 32'h6008, 32'h3);
    ifc.data_sram_addr_ok = 1'b1;
    step();
    ifc.data_sram_addr_ok = 1'b0;
    chk("pre_count", ifc.sq_count, 2);
    chk("pre_empty", ifc.sq_empty, 0);
    reset = 1'b1;
    step();
    chk("mrst_ready", ifc.st_ready, 1);
    chk("mrst_empty", ifc.sq_empty, 1);
    chk("mrst_count", ifc.sq_count, 0);
    chk("mrst_req", ifc.data_sram_req, 0);
    chk("mrst_wr", ifc.data_sram_wr, 0);
    chk("mrst_size", ifc.data_sram_size, 0);
    chk("mrst_addr", ifc.data_sram_addr, 0);
    chk("mrst_wstrb", ifc.data_sram_wstrb, 0);
    chk("mrst_wdata", ifc.data_sram_wdata, 0);
    step();
    reset = 1'b0;
    pend = 0;
    ifc.data_sram_data_ok = 1'b1;
    step();
    step();
    chk("stray_empty", ifc.sq_empty, 1);
    chk("stray_count", ifc.sq_count, 0);

    // normal operation resumes after reset
    log_q.delete();
    auto_dok = 1'b1;
    ifc.data_sram_addr_ok = 1'b1;
    enq(3'b000, 32'h7001, 32'h0000_005A);
    wait_empty("post_empty");
    chk("post_n", log_q.size(), 1);
    chk("post_wstrb", log_q[0].wstrb, 4'b0010);
    chk("post_wdata", log_q[0].wdata, 32'h5A5A_5A5A);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
